// File: rtl/sb_dma_copy.sv
// Single-outstanding word copy engine mastering the system bus.
// Copies len words from src to dst, aborting on a write error response.
module sb_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic             sb_clk,
  input  logic             sb_rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             sb_arvalid,
  input  logic             sb_arready,
  output logic [31:0]      sb_araddr,
  input  logic             sb_rvalid,
  output logic             sb_rready,
  input  logic [31:0]      sb_rdata,
  output logic             sb_wvalid,
  input  logic             sb_wready,
  output logic [31:0]      sb_waddr,
  output logic [31:0]      sb_wdata,
  output logic [3:0]       sb_wstrb,
  input  logic             sb_bvalid,
  output logic             sb_bready,
  input  logic             sb_bresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]      wr_ptr_q, wr_ptr_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             err_q, err_d;

  always_ff @(posedge sb_clk) begin
    if (sb_rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      data_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data_q   <= data_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    remain_d = remain_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d = src_addr & ~32'd3;
          wr_ptr_d = dst_addr & ~32'd3;
          remain_d = len;
          err_d    = 1'b0;
          state_d  = (len == '0) ? S_FIN : S_RADDR;
        end
      end
      S_RADDR: begin
        if (sb_arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (sb_rvalid) begin
          data_d  = sb_rdata;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (sb_wready) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (sb_bvalid) begin
          if (sb_bresp) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            rd_ptr_d = rd_ptr_q + 32'd4;
            wr_ptr_d = wr_ptr_q + 32'd4;
            remain_d = remain_q - LEN_W'(1);
            state_d  = (remain_q == LEN_W'(1)) ? S_FIN : S_RADDR;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every bus output is decoded from state or taken straight from a flop.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;
  assign sb_arvalid = (state_q == S_RADDR);
  assign sb_rready  = (state_q == S_RDATA);
  assign sb_wvalid  = (state_q == S_WRITE);
  assign sb_bready  = (state_q == S_WRESP);
  assign sb_araddr  = rd_ptr_q;
  assign sb_waddr   = wr_ptr_q;
  assign sb_wdata   = data_q;
  assign sb_wstrb   = 4'hF;

endmodule

// File: tb/tb_sb_dma_copy.sv
// Bench for sb_dma_copy: random-delay bus slave with a word memory
// and a copy-level reference model of the expected results.
module tb_sb_dma_copy;

  logic        sb_clk;
  logic        sb_rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        sb_arvalid, sb_arready;
  logic [31:0] sb_araddr;
  logic        sb_rvalid, sb_rready;
  logic [31:0] sb_rdata;
  logic        sb_wvalid, sb_wready;
  logic [31:0] sb_waddr, sb_wdata;
  logic [3:0]  sb_wstrb;
  logic        sb_bvalid, sb_bready, sb_bresp;

  sb_dma_copy #(.LEN_W(16)) dut (
    .sb_clk(sb_clk), .sb_rst(sb_rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
    .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata),
    .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
    .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
    .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_log [$];
  int max_dly = 0;
  int err_word = 0;
  bit hold_w = 0;
  int stall = 0, n_wr = 0;
  int busy_cyc = 0, done_cnt = 0, any_bus = 0;
  logic err_at_done = 0;

  int ar_cnt = 0, r_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] rd_word = 0;
  bit b_err = 0;
  bit ar_hold = 0, w_hold = 0;
  logic [31:0] ar_hold_addr = 0, w_hold_addr = 0, w_hold_data = 0;

  // Slave responder: decides each ready/valid half a cycle before the edge.
  always @(negedge sb_clk) begin
    if (sb_rst) begin
      sb_arready = 0; sb_rvalid = 0; sb_wready = 0;
      sb_bvalid = 0; sb_bresp = 0;
      ar_hold = 0; w_hold = 0;
    end else begin
      if (ar_hold) begin
        chk("ar_valid_held", {31'd0, sb_arvalid}, 32'd1);
        chk("ar_addr_stable", sb_araddr, ar_hold_addr);
      end
      if (w_hold) begin
        chk("w_valid_held", {31'd0, sb_wvalid}, 32'd1);
        chk("w_addr_stable", sb_waddr, w_hold_addr);
        chk("w_data_stable", sb_wdata, w_hold_data);
      end
      sb_arready = 0;
      if (sb_arvalid) begin
        if (ar_cnt == 0) begin
          sb_arready = 1;
          ar_log.push_back(sb_araddr);
          rd_word = mem.exists(sb_araddr) ? mem[sb_araddr] : 32'd0;
        end else begin
          ar_cnt--; stall++;
        end
      end else ar_cnt = $urandom_range(max_dly, 0);
      ar_hold = sb_arvalid && !sb_arready;
      ar_hold_addr = sb_araddr;

      sb_rvalid = 0;
      if (sb_rready) begin
        if (r_cnt == 0) begin
          sb_rvalid = 1; sb_rdata = rd_word;
        end else begin
          r_cnt--; stall++;
        end
      end else r_cnt = $urandom_range(max_dly, 0);

      sb_wready = 0;
      if (sb_wvalid) begin
        if (w_cnt == 0 && !hold_w) begin
          sb_wready = 1;
          mem[sb_waddr] = sb_wdata;
          n_wr++;
          chk("wstrb", {28'd0, sb_wstrb}, 32'hF);
          b_err = (n_wr == err_word);
        end else begin
          if (w_cnt != 0) w_cnt--;
          stall++;
        end
      end else w_cnt = $urandom_range(max_dly, 0);
      w_hold = sb_wvalid && !sb_wready;
      w_hold_addr = sb_waddr;
      w_hold_data = sb_wdata;

      sb_bvalid = 0; sb_bresp = 0;
      if (sb_bready) begin
        if (b_cnt == 0) begin
          sb_bvalid = 1; sb_bresp = b_err;
        end else begin
          b_cnt--; stall++;
        end
      end else b_cnt = $urandom_range(max_dly, 0);
    end
  end

  always @(negedge sb_clk) begin
    if (!sb_rst) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; err_at_done = err;
      end
      if (sb_arvalid | sb_rready | sb_wvalid | sb_bready) any_bus++;
    end
  end

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input int ln, input int errw, input int dly,
                          input bit poke);
    logic [31:0] sa, da;
    logic [31:0] vals [$];
    int nw;
    bit got, exp_err;
    sa = src & ~32'd3;
    da = dst & ~32'd3;
    exp_err = (errw != 0 && errw <= ln);
    nw = exp_err ? errw : ln;
    vals.delete();
    for (int i = 0; i < ln; i++) begin
      vals.push_back($urandom);
      mem[sa + 32'(4 * i)] = vals[i];
    end
    max_dly = dly;
    err_word = errw;
    @(posedge sb_clk); #1;
    busy_cyc = 0; done_cnt = 0; any_bus = 0; stall = 0; n_wr = 0;
    ar_log.delete();
    start = 1; src_addr = src; dst_addr = dst; len = 16'(ln);
    @(posedge sb_clk); #1;
    start = 0; src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom);
    @(negedge sb_clk);
    chk("busy_n1", {31'd0, busy}, 32'd1);
    chk("done_n1", {31'd0, done}, {31'd0, ln == 0});
    chk("arvalid_n1", {31'd0, sb_arvalid}, {31'd0, ln != 0});
    chk("err_clr", {31'd0, err}, 32'd0);
    got = done;
    if (poke) begin
      @(posedge sb_clk); #1;
      start = 1; src_addr = 32'h5000; dst_addr = 32'h6000; len = 16'd9;
      @(posedge sb_clk); #1;
      start = 0;
    end
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge sb_clk);
      if (done) got = 1;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge sb_clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("err_at_done", {31'd0, err_at_done}, {31'd0, exp_err});
    chk("err_sticky", {31'd0, err}, {31'd0, exp_err});
    chk("busy_cycles", 32'(busy_cyc), 32'(4 * nw + 1 + stall));
    chk("n_writes", 32'(n_wr), 32'(nw));
    chk("n_reads", 32'(ar_log.size()), 32'(nw));
    for (int i = 0; i < nw && i < ar_log.size(); i++)
      chk("araddr", ar_log[i], sa + 32'(4 * i));
    for (int i = 0; i < nw; i++)
      chk("dst_word", mem.exists(da + 32'(4 * i)) ? mem[da + 32'(4 * i)] : 32'hDEAD_BEEF, vals[i]);
    if (ln == 0) chk("len0_no_bus", 32'(any_bus), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_valids", {28'd0, sb_arvalid, sb_rready, sb_wvalid, sb_bready}, 32'd0);
    chk("rst_araddr", sb_araddr, 32'd0);
    chk("rst_waddr", sb_waddr, 32'd0);
    chk("rst_wdata", sb_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, sb_wstrb}, 32'hF);
  endtask

  initial begin
    bit seen;
    sb_rst = 1; start = 0; src_addr = 0; dst_addr = 0; len = 0;
    sb_arready = 0; sb_rvalid = 0; sb_rdata = 0; sb_wready = 0;
    sb_bvalid = 0; sb_bresp = 0;
    repeat (3) @(posedge sb_clk);
    @(negedge sb_clk);
    chk_reset_vals();
    @(posedge sb_clk); #1;
    sb_rst = 0;

    run_copy(32'h100, 32'h200, 4, 0, 0, 0);
    run_copy(32'h100, 32'h200, 4, 0, 5, 0);
    run_copy(32'h400, 32'h600, 3, 2, 0, 0);
    run_copy(32'h100, 32'h200, 0, 0, 0, 0);
    run_copy(32'h103, 32'h702, 2, 0, 2, 0);
    run_copy(32'hFFFF_FFFC, 32'h300, 2, 0, 0, 0);
    run_copy(32'h800, 32'h900, 4, 0, 0, 1);
    run_copy(32'hA00, 32'hB00, 5, 4, 3, 0);

    // Abandon a copy while its write is stalled.
    hold_w = 1; max_dly = 0;
    @(posedge sb_clk); #1;
    start = 1; src_addr = 32'h100; dst_addr = 32'h200; len = 16'd3;
    @(posedge sb_clk); #1;
    start = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge sb_clk);
      if (sb_wvalid) seen = 1;
    end
    chk("reach_write", {31'd0, seen}, 32'd1);
    @(posedge sb_clk); #1;
    sb_rst = 1;
    @(posedge sb_clk);
    @(negedge sb_clk);
    chk_reset_vals();
    @(posedge sb_clk); #1;
    sb_rst = 0; hold_w = 0;
    run_copy(32'hC00, 32'hD00, 3, 0, 0, 0);

    for (int k = 0; k < 6; k++)
      run_copy(32'h1000 + 32'($urandom_range(255, 0)),
               32'h8000 + 32'($urandom_range(255, 0)),
               $urandom_range(6, 1), 0, $urandom_range(5, 0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
